// File: rtl/cache_pkg.sv
// Shared definitions for the L2 replacement unit: policy encodings,
// random-generator taps and small helper functions.
package cache_pkg;

  localparam logic [1:0] POL_RANDOM = 2'd0;
  localparam logic [1:0] POL_PLRU   = 2'd1;
  localparam logic [1:0] POL_LRU    = 2'd2;

  // Fibonacci taps 16,14,13,11 expressed as a mask over bits [15:0]
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Index of the lowest clear bit; returns 0 when every bit is set
  function automatic logic [3:0] lowest_zero(input logic [15:0] v);
    logic [3:0] r;
    r = '0;
    for (int i = 15; i >= 0; i--) begin
      if (!v[i]) r = 4'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/l2_replacement_unit_if.sv
// Lookup request / result bundle between the L2 tag path and the replacement unit.
interface l2_replacement_unit_if #(
  parameter int WAYS = 4,
  parameter int SETS = 16
);
  localparam int IDX_W = cache_pkg::clog2(SETS);
  localparam int WAY_W = cache_pkg::clog2(WAYS);

  logic [1:0]       policy;
  logic             lookup_valid;
  logic [IDX_W-1:0] lookup_index;
  logic             lookup_hit;
  logic [WAY_W-1:0] lookup_way;
  logic [WAYS-1:0]  valid_mask;
  logic             stats_clr;
  logic             result_valid;
  logic             result_hit;
  logic [WAY_W-1:0] victim_way;
  logic [31:0]      hit_count;
  logic [31:0]      miss_count;

  modport master (
    output policy, lookup_valid, lookup_index, lookup_hit, lookup_way, valid_mask, stats_clr,
    input  result_valid, result_hit, victim_way, hit_count, miss_count
  );

  modport slave (
    input  policy, lookup_valid, lookup_index, lookup_hit, lookup_way, valid_mask, stats_clr,
    output result_valid, result_hit, victim_way, hit_count, miss_count
  );

endinterface

// File: rtl/repl_lfsr.sv
// Free-running 16-bit Fibonacci LFSR supplying random victim bits.
module repl_lfsr
  import cache_pkg::*;
#(
  parameter logic [15:0] SEED  = 16'hACE1,
  parameter int          OUT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  output logic [OUT_W-1:0] o_rand
);

  logic [15:0] r_lfsr;
  logic        w_fb;

  assign w_fb   = ^(r_lfsr & LFSR_TAPS);
  assign o_rand = r_lfsr[OUT_W-1:0];

  // Shift left each enabled cycle, feeding the tap parity into bit 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_lfsr <= SEED;
    else if (i_en) r_lfsr <= {r_lfsr[14:0], w_fb};
  end

endmodule

// File: rtl/l2_replacement_unit.sv
// L2 victim selection (RANDOM / PLRU / LRU) with per-set recency state
// and saturating hit/miss statistics.
module l2_replacement_unit
  import cache_pkg::*;
#(
  parameter int          WAYS      = 4,
  parameter int          SETS      = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input logic                  clk,
  input logic                  rst_n,
  l2_replacement_unit_if.slave bus
);

  localparam int IDX_W = clog2(SETS);
  localparam int WAY_W = clog2(WAYS);

  // PLRU tree per set: node 1 is the root, node n has children 2n and 2n+1
  logic [WAYS-1:1]  r_plru [SETS];
  logic [WAY_W-1:0] r_age  [SETS][WAYS];
  logic             r_result_valid;
  logic             r_result_hit;
  logic [WAY_W-1:0] r_victim;
  logic [31:0]      r_hit_count;
  logic [31:0]      r_miss_count;

  logic [IDX_W-1:0] w_idx;
  logic [15:0]      w_mask16;
  logic [WAY_W-1:0] w_rand;
  logic [WAY_W-1:0] w_inv_way;
  logic [WAY_W-1:0] w_plru_way;
  logic [WAY_W-1:0] w_lru_way;
  logic [WAY_W-1:0] w_miss_way;
  logic [WAY_W-1:0] w_touch_way;
  logic [WAY_W-1:0] w_touch_age;
  logic [WAYS-1:1]  w_tree_next;
  logic [WAY_W-1:0] w_age_next [WAYS];

  repl_lfsr #(.SEED(LFSR_SEED), .OUT_W(WAY_W)) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (1'b1),
    .o_rand (w_rand)
  );

  assign w_idx       = bus.lookup_index;
  assign w_inv_way   = WAY_W'(lowest_zero(w_mask16));
  assign w_touch_way = bus.lookup_hit ? bus.lookup_way : w_miss_way;
  assign w_touch_age = r_age[w_idx][w_touch_way];

  // Pad the valid mask to 16 bits with ones so absent ways never look invalid
  always_comb begin
    w_mask16               = '1;
    w_mask16[WAYS-1:0]     = bus.valid_mask;
  end

  // Walk the addressed PLRU tree from the root; a 0 bit steers towards lower ways
  always_comb begin
    logic [WAY_W-1:0] n;
    n = WAY_W'(1);
    for (int l = 0; l < WAY_W; l++) n = (n << 1) | WAY_W'(r_plru[w_idx][n]);
    w_plru_way = n;
  end

  // The least recently used way is the one carrying the oldest age
  always_comb begin
    w_lru_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_age[w_idx][w] == WAY_W'(WAYS - 1)) w_lru_way = WAY_W'(w);
    end
  end

  // Miss victim: any invalid way first, otherwise the active policy (3 behaves as LRU)
  always_comb begin
    w_miss_way = w_lru_way;
    if (bus.valid_mask != '1) begin
      w_miss_way = w_inv_way;
    end else begin
      case (bus.policy)
        POL_RANDOM: w_miss_way = w_rand;
        POL_PLRU:   w_miss_way = w_plru_way;
        default:    w_miss_way = w_lru_way;
      endcase
    end
  end

  // Touched way becomes youngest; ways younger than it age by one
  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      w_age_next[w] = r_age[w_idx][w];
      if (WAY_W'(w) == w_touch_way)               w_age_next[w] = '0;
      else if (r_age[w_idx][w] < w_touch_age)     w_age_next[w] = r_age[w_idx][w] + 1'b1;
    end
  end

  // Point every node on the path to the touched way away from it
  always_comb begin
    logic [WAY_W-1:0] n;
    logic [WAY_W-1:0] path;
    w_tree_next = r_plru[w_idx];
    n           = WAY_W'(1);
    path        = w_touch_way;
    for (int l = 0; l < WAY_W; l++) begin
      w_tree_next[n] = ~path[WAY_W-1];
      n              = (n << 1) | WAY_W'(path[WAY_W-1]);
      path           = path << 1;
    end
  end

  // Both recency structures track every lookup so the policy can change at any time
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        r_plru[s] <= '0;
        for (int w = 0; w < WAYS; w++) r_age[s][w] <= WAY_W'(w);
      end
    end else if (bus.lookup_valid) begin
      r_plru[w_idx] <= w_tree_next;
      for (int w = 0; w < WAYS; w++) r_age[w_idx][w] <= w_age_next[w];
    end
  end

  // Register the lookup outcome; victim and hit flag hold between lookups
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result_valid <= 1'b0;
      r_result_hit   <= 1'b0;
      r_victim       <= '0;
    end else begin
      r_result_valid <= bus.lookup_valid;
      if (bus.lookup_valid) begin
        r_result_hit <= bus.lookup_hit;
        r_victim     <= w_touch_way;
      end
    end
  end

  // Saturating statistics; a clear beats any same-cycle increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else if (bus.stats_clr) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else if (bus.lookup_valid) begin
      if (bus.lookup_hit) begin
        if (r_hit_count != '1) r_hit_count <= r_hit_count + 32'd1;
      end else if (r_miss_count != '1) begin
        r_miss_count <= r_miss_count + 32'd1;
      end
    end
  end

  assign bus.result_valid = r_result_valid;
  assign bus.result_hit   = r_result_hit;
  assign bus.victim_way   = r_victim;
  assign bus.hit_count    = r_hit_count;
  assign bus.miss_count   = r_miss_count;

endmodule

// File: tb/tb_l2_replacement_unit.sv
// Bench for l2_replacement_unit: directed vector table, hand-written corner
// sequences and randomized lookups checked against a behavioural model.
module tb_l2_replacement_unit;

  localparam int          WAYS  = 4;
  localparam int          SETS  = 16;
  localparam int          IDX_W = 4;
  localparam logic [15:0] SEED  = 16'hACE1;
  localparam longint      CMAX  = 64'h0000_0000_FFFF_FFFF;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  l2_replacement_unit_if #(.WAYS(WAYS), .SETS(SETS)) bus ();

  l2_replacement_unit #(.WAYS(WAYS), .SETS(SETS), .LFSR_SEED(SEED)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int totalChecks = 0;
  int passChecks  = 0;

  // Reference model: LRU as a recency-ordered list (front = most recent),
  // PLRU as a 0-based heap of direction bits, LFSR as a plain 16-bit value.
  int          mLru  [SETS][$];
  bit          mPlru [SETS][WAYS];
  logic [15:0] mLfsr;
  longint      mHit;
  longint      mMiss;
  bit          expValid;
  bit          expHit;
  int          expVictim;

  typedef struct {
    logic [1:0]      pol;
    int              idx;
    bit              hit;
    int              way;
    logic [WAYS-1:0] mask;
    int              expVictim;
    bit              expHit;
  } vec_t;

  vec_t vecs [14];

  task automatic checkVal(input string name, input longint act, input longint exp);
    totalChecks++;
    if (act == exp) passChecks++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [15:0] lfsrNext(input logic [15:0] x);
    logic fb;
    fb = x[15] ^ x[13] ^ x[12] ^ x[10];
    return {x[14:0], fb};
  endfunction

  task automatic modelReset();
    for (int s = 0; s < SETS; s++) begin
      mLru[s].delete();
      for (int w = 0; w < WAYS; w++) begin
        mLru[s].push_back(w);
        mPlru[s][w] = 1'b0;
      end
    end
    mLfsr     = SEED;
    mHit      = 0;
    mMiss     = 0;
    expValid  = 1'b0;
    expHit    = 1'b0;
    expVictim = 0;
  endtask

  function automatic int plruVictim(input int s);
    int n;
    n = 0;
    while (n < WAYS - 1) n = 2 * n + 1 + int'(mPlru[s][n]);
    return n - (WAYS - 1);
  endfunction

  function automatic void plruTouch(input int s, input int way);
    int n, p;
    n = way + WAYS - 1;
    while (n > 0) begin
      p = (n - 1) / 2;
      mPlru[s][p] = (n == 2 * p + 1);
      n = p;
    end
  endfunction

  function automatic void lruTouch(input int s, input int way);
    for (int k = 0; k < mLru[s].size(); k++) begin
      if (mLru[s][k] == way) begin
        mLru[s].delete(k);
        break;
      end
    end
    mLru[s].push_front(way);
  endfunction

  function automatic int lowestInvalid(input logic [WAYS-1:0] mask);
    for (int w = 0; w < WAYS; w++) if (!mask[w]) return w;
    return 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst_n) mLfsr = lfsrNext(mLfsr);
    #1;
  endtask

  task automatic applyStimulus(input bit v, input logic [1:0] pol, input int idx, input bit hit,
                               input int way, input logic [WAYS-1:0] mask, input bit clr);
    int victim;
    bus.lookup_valid = v;
    bus.policy       = pol;
    bus.lookup_index = IDX_W'(idx);
    bus.lookup_hit   = hit;
    bus.lookup_way   = 2'(way);
    bus.valid_mask   = mask;
    bus.stats_clr    = clr;
    if (clr) begin
      mHit  = 0;
      mMiss = 0;
    end else if (v) begin
      if (hit) mHit  = (mHit  == CMAX) ? CMAX : mHit + 1;
      else     mMiss = (mMiss == CMAX) ? CMAX : mMiss + 1;
    end
    if (v) begin
      if (hit)                  victim = way;
      else if (mask != '1)      victim = lowestInvalid(mask);
      else if (pol == 2'd0)     victim = int'(mLfsr) % WAYS;
      else if (pol == 2'd1)     victim = plruVictim(idx);
      else                      victim = mLru[idx][$];
      plruTouch(idx, victim);
      lruTouch(idx, victim);
      expVictim = victim;
      expHit    = hit;
    end
    expValid = v;
    tick();
  endtask

  task automatic checkOutput(input string name);
    checkVal({name, ".valid"}, longint'(bus.result_valid), longint'(expValid));
    if (expValid) checkVal({name, ".hit"}, longint'(bus.result_hit), longint'(expHit));
    checkVal({name, ".victim"}, longint'(bus.victim_way), longint'(expVictim));
    checkVal({name, ".hits"},   longint'(bus.hit_count),  mHit);
    checkVal({name, ".misses"}, longint'(bus.miss_count), mMiss);
  endtask

  task automatic idleInputs();
    bus.lookup_valid = 1'b0;
    bus.policy       = 2'd2;
    bus.lookup_index = '0;
    bus.lookup_hit   = 1'b0;
    bus.lookup_way   = '0;
    bus.valid_mask   = '1;
    bus.stats_clr    = 1'b0;
  endtask

  task automatic doReset();
    idleInputs();
    rst_n = 1'b0;
    modelReset();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    // pol, set, hit, way, mask, expected victim, expected hit
    vecs[0]  = '{2'd2, 3, 1'b0, 0, 4'b0111, 3, 1'b0};
    vecs[1]  = '{2'd2, 0, 1'b1, 0, 4'b1111, 0, 1'b1};
    vecs[2]  = '{2'd2, 0, 1'b1, 1, 4'b1111, 1, 1'b1};
    vecs[3]  = '{2'd2, 0, 1'b1, 2, 4'b1111, 2, 1'b1};
    vecs[4]  = '{2'd2, 0, 1'b1, 3, 4'b1111, 3, 1'b1};
    vecs[5]  = '{2'd2, 0, 1'b0, 0, 4'b1111, 0, 1'b0};
    vecs[6]  = '{2'd2, 0, 1'b0, 0, 4'b1111, 1, 1'b0};
    vecs[7]  = '{2'd1, 5, 1'b1, 0, 4'b1111, 0, 1'b1};
    vecs[8]  = '{2'd1, 5, 1'b0, 0, 4'b1111, 2, 1'b0};
    vecs[9]  = '{2'd2, 5, 1'b0, 0, 4'b1111, 3, 1'b0};
    vecs[10] = '{2'd3, 5, 1'b0, 0, 4'b1111, 1, 1'b0};
    vecs[11] = '{2'd1, 5, 1'b0, 0, 4'b1111, 2, 1'b0};
    vecs[12] = '{2'd0, 7, 1'b0, 0, 4'b1011, 2, 1'b0};
    vecs[13] = '{2'd1, 9, 1'b0, 0, 4'b1110, 0, 1'b0};

    doReset();
    checkOutput("reset");

    foreach (vecs[i]) begin
      applyStimulus(1'b1, vecs[i].pol, vecs[i].idx, vecs[i].hit, vecs[i].way, vecs[i].mask, 1'b0);
      checkOutput($sformatf("vec%0d", i));
      checkVal($sformatf("vec%0d.tableVictim", i), longint'(bus.victim_way), longint'(vecs[i].expVictim));
      checkVal($sformatf("vec%0d.tableHit", i), longint'(bus.result_hit), longint'(vecs[i].expHit));
    end

    applyStimulus(1'b0, 2'd2, 0, 1'b0, 0, 4'b1111, 1'b0);
    checkOutput("idleHold");

    // Random policy from a fresh seed: eight back-to-back misses to a full set
    doReset();
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, 2'd0, 1, 1'b0, 0, 4'b1111, 1'b0);
      checkOutput($sformatf("lfsr%0d", k));
    end

    // Hit counter saturation, then a clear colliding with a hit
    force dut.r_hit_count = 32'hFFFF_FFFE;
    #2;
    release dut.r_hit_count;
    mHit = 64'h0000_0000_FFFF_FFFE;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 2'd2, 4, 1'b1, 1, 4'b1111, 1'b0);
      checkOutput($sformatf("sat%0d", k));
    end
    applyStimulus(1'b1, 2'd2, 4, 1'b1, 2, 4'b1111, 1'b1);
    checkOutput("clrWithHit");

    // Reset asserted in the middle of back-to-back lookups
    applyStimulus(1'b1, 2'd2, 6, 1'b0, 0, 4'b1111, 1'b0);
    checkOutput("preReset0");
    applyStimulus(1'b1, 2'd2, 6, 1'b1, 2, 4'b1111, 1'b0);
    checkOutput("preReset1");
    bus.lookup_valid = 1'b1;
    bus.lookup_hit   = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("midReset");
    tick();
    rst_n = 1'b1;
    applyStimulus(1'b0, 2'd2, 6, 1'b0, 0, 4'b1111, 1'b0);
    checkOutput("afterReset");
    applyStimulus(1'b1, 2'd2, 6, 1'b0, 0, 4'b1111, 1'b0);
    checkOutput("lruAfterReset");
    checkVal("lruAfterReset.oldest", longint'(bus.victim_way), longint'(WAYS - 1));

    // Randomized traffic concentrated on a few sets to stress recency state
    for (int i = 0; i < 300; i++) begin
      logic [WAYS-1:0] m;
      m = ($urandom_range(0, 1) == 0) ? 4'b1111 : 4'($urandom);
      applyStimulus($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    $urandom_range(0, 1) == 1, int'($urandom_range(0, WAYS - 1)), m,
                    $urandom_range(0, 31) == 0);
      checkOutput($sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", passChecks, totalChecks);
    $finish;
  end

endmodule

// File: doc/l2_replacement_unit.md
# l2_replacement_unit

Parametrised victim-selection and statistics engine for the set-associative L2 cache, sitting beside the L2 tag array between the L1/L2 request path and the L2/memory fill path. Per lookup it updates per-set recency state and, on a miss, nominates a victim way under a runtime-selectable policy (RANDOM, PLRU, LRU). It generalises the fixed replacement/counter logic to any power-of-two way count and set count. It adds invalid-way preference, live policy switching and saturating hit/miss counters.

## Interface
- WAYS, 4, associativity; power of two, 2..16
- SETS, 16, number of sets; power of two, 2..256
- LFSR_SEED, 16'hACE1, reset value of random LFSR; must be nonzero
- IDX_W, log2(SETS), derived set-index width
- WAY_W, log2(WAYS), derived way-number width
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- policy  in  2  0=RANDOM, 1=PLRU, 2=LRU, 3=treated as LRU
- lookup_valid  in  1  one lookup this cycle
- lookup_index  in  IDX_W  set addressed
- lookup_hit  in  1  tag compare hit
- lookup_way  in  WAY_W  hitting way; ignored on miss
- valid_mask  in  WAYS  per-way valid bits of the addressed set
- stats_clr  in  1  synchronous clear of both counters
- result_valid  out  1  registered pulse, one cycle after lookup_valid
- result_hit  out  1  registered copy of lookup_hit
- victim_way  out  WAY_W  chosen way on miss; hit way on hit
- hit_count  out  32  saturating hit counter
- miss_count  out  32  saturating miss counter

## Operation
- Reset: result_valid=0, result_hit=0, victim_way=0, counters=0, PLRU bits all 0, LRU age of way i = i in every set, LFSR=LFSR_SEED.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, advances every cycle regardless of lookups.
- Miss victim selection, in priority order:
  - If valid_mask is not all ones, the lowest-numbered invalid way wins under every policy.
  - Else, under RANDOM: LFSR[WAY_W-1:0].
  - Else, under PLRU: walk the tree (WAYS-1 bits per set) from root; a bit of 0 goes left and 1 goes right.
  - Else, under LRU: the way whose age is WAYS-1.
- Recency update on every lookup uses the touched way: the hit way on a hit, the victim on a miss (the fill is assumed).
  - LRU: ages below the touched way's age increment; the touched way's age becomes 0. Ages stay a permutation of 0..WAYS-1.
  - PLRU: every node on the path to the touched way is set to point away from it.
- Both PLRU and LRU state are maintained under every policy, so switching policy mid-run is safe. A change takes effect on the next lookup.
- Counters: a hit increments hit_count and a miss increments miss_count. Each holds at 32'hFFFFFFFF. stats_clr wins over a same-cycle increment.

## Timing
- Lookup in cycle N: victim computed combinationally from cycle-N state; result_* registered at the end of cycle N; state updated on the same edge.
- Fully pipelined: one lookup per cycle, no ready/stall.
- Back-to-back lookups to the same set see the prior update; no hazard window.
- result_valid is low in any cycle following a cycle with lookup_valid=0; victim_way holds its last value.
- rst_n assertion mid-stream clears all state immediately. A lookup in flight produces no result_valid.

## Structure
- Shared package cache_pkg: policy encodings RANDOM=0, PLRU=1, LRU=2; the LFSR tap constant; helper functions for clog2 and lowest-zero-bit.
- Sub-module repl_lfsr: parametrised seed, enable tied high.
- Top level holds per-set PLRU tree bits and LRU age vectors as flop arrays, because async reset is required.

## Test plan
- Reset with WAYS=4, then a miss to set 3 with valid_mask=4'b0111 -> next cycle result_valid=1, victim_way=3, miss_count=1.
- LRU, all ways valid, hits on set 0 ways 0,1,2,3 then a miss -> victim_way=0; immediate second miss to set 0 -> victim_way=1.
- PLRU, WAYS=4, all valid, hit way 0 then miss -> victim_way=2; switch policy to LRU mid-stream -> next miss victim matches LRU model.
- RANDOM with seed 16'hACE1: 8 consecutive misses every cycle -> victims equal the low WAY_W bits of the reference LFSR sequence.
- Force hit_count=32'hFFFFFFFE, issue 3 hits -> counter holds 32'hFFFFFFFF; stats_clr asserted with a hit in the same cycle -> 0.
- Assert rst_n low during back-to-back lookups -> result_valid=0 immediately; next miss to any full set under LRU -> victim_way=WAYS-1.
